paddle_arbiter: RTL and testbench
=================================

// Module: paddle_arbiter
// PURPOSE
//  Owns both paddle position registers and sequences their updates through one shared
//  add/clamp datapath. Once per movement tick it serves both players in round-robin order,
//  so one player's input never starves the other. Sits between raw button/PMOD inputs and
//  the VGA pixel logic; p1_pos/p2_pos are the paddle centre rows consumed by the renderer.
// PARAMETERS
//  TICK_PERIOD  524288  board_clk cycles per movement tick (legal: >= 4)
//  STEP         5       rows moved per served request
//  POS_MIN      40      smallest legal paddle centre row
//  POS_MAX      440     largest legal paddle centre row
//  POS_INIT     240     centre row after reset/recenter
// PORTS
//  board_clk  in   1   system clock
//  reset      in   1   reset, asynchronous, active-high; clock board_clk
//  recenter   in   1   synchronous level; return both paddles to POS_INIT (serve/ack)
//  p1_up      in   1   async raw; player 1 up (toward row 0)
//  p1_dn      in   1   async raw; player 1 down
//  p2_up      in   1   async raw; player 2 up
//  p2_dn      in   1   async raw; player 2 down
//  p1_pos     out  10  player 1 paddle centre row
//  p2_pos     out  10  player 2 paddle centre row
//  grant      out  2   one-hot, cycle the shared datapath writes: [0]=P1, [1]=P2
//  tick       out  1   1-cycle pulse at each movement tick
//  busy       out  1   high while FSM is not IDLE
// BEHAVIOUR
//  - Reset: p1_pos=p2_pos=POS_INIT, grant=0, tick=0, busy=0, prescaler=0, rr_ptr=P1, FSM=IDLE.
//  - p*_up/p*_dn pass through 2-flop synchronizers; requests use synchronized values only.
//  - Prescaler counts 0..TICK_PERIOD-1 and wraps; tick=1 in the cycle the count is TICK_PERIOD-1.
//  - req_i = up_i ^ dn_i; dir_i = up_i (1=up). Both or neither pressed -> no request.
//  - FSM: IDLE -> (tick) LATCH: capture req/dir of both players into snapshot, busy=1.
//    LATCH -> SERVE_A: serve first = rr_ptr if req[rr_ptr] else other player.
//    SERVE_A -> SERVE_B: serve the remaining requester, if any. SERVE_B -> IDLE.
//    A slot with no requester writes nothing and holds grant=0.
//  - rr_ptr toggles at the end of every tick in which both players were served, so the first
//    slot alternates. Otherwise rr_ptr holds.
//  - Latency: tick at cycle T; first update visible at T+3, second at T+4; busy high T+1..T+3.
//  - Update arithmetic, 10-bit unsigned, done in the shared datapath:
//    up:   pos' = (pos >= POS_MIN+STEP) ? pos-STEP : POS_MIN
//    down: pos' = (pos + STEP <= POS_MAX) ? pos+STEP : POS_MAX
//    Compare at 11 bits; no wrap-around is possible.
//  - recenter has top priority, evaluated every cycle. Both pos go to POS_INIT next cycle,
//    FSM->IDLE, the pending snapshot is dropped, prescaler->0, grant=0. rr_ptr is held.
//  - Input changes after LATCH do not affect the current tick's service.
//  - reset mid-service: immediate async return to the reset values.
// CONFIGURATION
//  PADDLE_ACCEL_EN defined: each player has a 3-bit hold counter. It increments on each
//    served tick in the same direction as the previous one and saturates at 7. It clears on
//    no request, a direction change, recenter or reset. At count 7 the step is 2*STEP, with
//    the same clamp rules.
//  PADDLE_ACCEL_EN undefined: no hold counters; step is always STEP.
// TESTING (bench uses TICK_PERIOD=8)
//  1 reset released -> p1_pos=p2_pos=240, grant=0, busy=0; tick every 8 cycles.
//  2 hold p1_up only -> after one tick p1_pos=235, grant=01 for 1 cycle, p2_pos=240.
//  3 p1_dn & p2_up held together -> tick n: grant 01 then 10 (p1=245, p2=235);
//    tick n+1: grant 10 then 01.
//  4 p1_pos=42, hold p1_up -> 40 after the next tick, stays 40 afterwards;
//    p2_pos=438, hold p2_dn -> 440 and holds.
//  5 p2_up & p2_dn both high -> no grant, p2_pos unchanged across 3 ticks.
//  6 recenter asserted the cycle after LATCH -> no grant in that tick, both pos=240,
//    busy=0 next cycle.
//  7 (PADDLE_ACCEL_EN) hold p1_dn from 240 -> steps of 5 for 8 ticks, then 10 per tick;
//    release -> next press moves 5.

Source files
------------

// File: rtl/paddle_arbiter.sv
// Paddle position owner: one shared add/clamp datapath serves both players round-robin per movement tick.
// Optional PADDLE_ACCEL_EN macro: per-player hold counters double the step after sustained same-direction motion.
module paddle_arbiter #(
    parameter int TICK_PERIOD = 524288,
    parameter int STEP        = 5,
    parameter int POS_MIN     = 40,
    parameter int POS_MAX     = 440,
    parameter int POS_INIT    = 240
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       recenter,
    input  logic       p1_up,
    input  logic       p1_dn,
    input  logic       p2_up,
    input  logic       p2_dn,
    output logic [9:0] p1_pos,
    output logic [9:0] p2_pos,
    output logic [1:0] grant,
    output logic       tick,
    output logic       busy
);

    localparam int CW = (TICK_PERIOD > 1) ? $clog2(TICK_PERIOD) : 1;
    localparam logic [CW-1:0] TICK_LAST = CW'(TICK_PERIOD - 1);
    localparam logic [10:0]   MIN11     = 11'(POS_MIN);
    localparam logic [10:0]   MAX11     = 11'(POS_MAX);
    localparam logic [9:0]    INIT10    = 10'(POS_INIT);

    typedef enum logic [1:0] {IDLE, LATCH, SERVE_A, SERVE_B} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] presc;
    logic [3:0]    sync1, sync2;
    logic [1:0]    req, dir;
    logic [1:0]    snap_req, snap_dir;
    logic          rr_ptr;
    logic          first, sel, wr_en;
    logic [9:0]    cur_pos, nxt_pos;
    logic [10:0]   cur11, step11, res11;

    // Bit order {p2_dn, p2_up, p1_dn, p1_up}
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {p2_dn, p2_up, p1_dn, p1_up};
            sync2 <= sync1;
        end
    end

    assign req  = {sync2[2] ^ sync2[3], sync2[0] ^ sync2[1]};
    assign dir  = {sync2[2], sync2[0]};
    assign tick = (presc == TICK_LAST);
    assign busy = (state != IDLE);

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset)
            presc <= '0;
        else if (recenter || tick)
            presc <= '0;
        else
            presc <= presc + CW'(1);
    end

    assign first = snap_req[rr_ptr] ? rr_ptr : ~rr_ptr;

    always_comb begin
        state_nxt = state;
        sel       = 1'b0;
        wr_en     = 1'b0;
        case (state)
            IDLE:    if (tick) state_nxt = LATCH;
            LATCH:   state_nxt = SERVE_A;
            SERVE_A: begin
                sel       = first;
                wr_en     = snap_req[first];
                state_nxt = SERVE_B;
            end
            SERVE_B: begin
                sel       = ~first;
                wr_en     = snap_req[~first];
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (recenter) begin
            state_nxt = IDLE;
            wr_en     = 1'b0;
        end
    end

    assign grant = wr_en ? (sel ? 2'b10 : 2'b01) : 2'b00;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Snapshot freezes the tick's requests; later input changes wait for the next tick
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            snap_req <= '0;
            snap_dir <= '0;
        end else if (recenter) begin
            snap_req <= '0;
            snap_dir <= '0;
        end else if (state == LATCH) begin
            snap_req <= req;
            snap_dir <= dir;
        end
    end

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset)
            rr_ptr <= 1'b0;
        else if (!recenter && state == SERVE_B && (&snap_req))
            rr_ptr <= ~rr_ptr;
    end

`ifdef PADDLE_ACCEL_EN
    logic [2:0] hold [2];
    logic [1:0] last_vld, last_dir;

    assign step11 = (hold[sel] == 3'd7) ? 11'(2 * STEP) : 11'(STEP);

    // Counters advance after both slots so each slot's step uses the pre-tick count
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            hold[0]  <= '0;
            hold[1]  <= '0;
            last_vld <= '0;
            last_dir <= '0;
        end else if (recenter) begin
            hold[0]  <= '0;
            hold[1]  <= '0;
            last_vld <= '0;
        end else if (state == SERVE_B) begin
            for (int i = 0; i < 2; i++) begin
                if (snap_req[i] && last_vld[i] && last_dir[i] == snap_dir[i])
                    hold[i] <= (hold[i] == 3'd7) ? 3'd7 : hold[i] + 3'd1;
                else
                    hold[i] <= '0;
                last_vld[i] <= snap_req[i];
                last_dir[i] <= snap_dir[i];
            end
        end
    end
`else
    assign step11 = 11'(STEP);
`endif

    assign cur_pos = sel ? p2_pos : p1_pos;
    assign cur11   = {1'b0, cur_pos};

    always_comb begin
        res11 = cur11;
        if (snap_dir[sel])
            res11 = (cur11 >= MIN11 + step11) ? cur11 - step11 : MIN11;
        else
            res11 = (cur11 + step11 <= MAX11) ? cur11 + step11 : MAX11;
    end

    assign nxt_pos = res11[9:0];

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            p1_pos <= INIT10;
            p2_pos <= INIT10;
        end else if (recenter) begin
            p1_pos <= INIT10;
            p2_pos <= INIT10;
        end else if (wr_en) begin
            if (sel)
                p2_pos <= nxt_pos;
            else
                p1_pos <= nxt_pos;
        end
    end

endmodule

// File: tb/tb_paddle_arbiter.sv
// Randomized bench for paddle_arbiter with a per-tick behavioural model of positions, service order and rotation.
module tb_paddle_arbiter;

    logic       board_clk = 1'b0;
    logic       reset, recenter;
    logic       p1_up, p1_dn, p2_up, p2_dn;
    logic [9:0] p1_pos, p2_pos;
    logic [1:0] grant;
    logic       tick, busy;

    int n_chk  = 0;
    int n_fail = 0;

    int m_pos [2];
    int m_rr;
    int m_hold [2];
    int m_lvld [2];
    int m_ldir [2];
    int cyc = 0;
    int last_tick = -1;

    paddle_arbiter #(.TICK_PERIOD(8), .STEP(5), .POS_MIN(40), .POS_MAX(440), .POS_INIT(240)) dut (
        .board_clk(board_clk), .reset(reset), .recenter(recenter),
        .p1_up(p1_up), .p1_dn(p1_dn), .p2_up(p2_up), .p2_dn(p2_dn),
        .p1_pos(p1_pos), .p2_pos(p2_pos), .grant(grant), .tick(tick), .busy(busy)
    );

    always #5 board_clk = ~board_clk;
    always @(posedge board_clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int move(input int pos, input int up, input int step);
        if (up != 0) return (pos - step < 40) ? 40 : pos - step;
        return (pos + step > 440) ? 440 : pos + step;
    endfunction

    task automatic model_clear();
        m_pos[0] = 240; m_pos[1] = 240;
        for (int i = 0; i < 2; i++) begin
            m_hold[i] = 0; m_lvld[i] = 0; m_ldir[i] = 0;
        end
    endtask

    task automatic check_pos(input string tag);
        check({tag, "_p1"}, 32'(p1_pos), 32'(m_pos[0]));
        check({tag, "_p2"}, 32'(p2_pos), 32'(m_pos[1]));
    endtask

    // Inputs {p2_dn, p2_up, p1_dn, p1_up}; called well before the tick so the synchronizers settle
    task automatic do_tick(input logic [3:0] in);
        int req [2];
        int dr [2];
        int order [2];
        int seen;
        {p2_dn, p2_up, p1_dn, p1_up} = in;
        req[0] = int'(in[0] ^ in[1]); dr[0] = int'(in[0]);
        req[1] = int'(in[2] ^ in[3]); dr[1] = int'(in[2]);
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge board_clk);
            if (tick) begin seen = 1; break; end
        end
        if (seen == 0) begin
            check("tick_timeout", 0, 1);
            return;
        end
        if (last_tick >= 0) check("tick_period", 32'(cyc - last_tick), 8);
        last_tick = cyc;
        order[0] = (req[m_rr] != 0) ? m_rr : 1 - m_rr;
        order[1] = 1 - order[0];
        @(negedge board_clk);
        check("latch_busy", 32'(busy), 1);
        check("latch_grant", 32'(grant), 0);
        for (int s = 0; s < 2; s++) begin
            int p;
            int st;
            p = order[s];
            @(negedge board_clk);
            check("slot_busy", 32'(busy), 1);
            check("slot_grant", 32'(grant), (req[p] != 0) ? (1 << p) : 0);
            if (s == 1) check_pos("after_a");
            if (req[p] != 0) begin
                st = 5;
`ifdef PADDLE_ACCEL_EN
                if (m_hold[p] == 7) st = 10;
`endif
                m_pos[p] = move(m_pos[p], dr[p], st);
            end
        end
        if (req[0] != 0 && req[1] != 0) m_rr = 1 - m_rr;
        for (int i = 0; i < 2; i++) begin
            if (req[i] != 0 && m_lvld[i] != 0 && m_ldir[i] == dr[i])
                m_hold[i] = (m_hold[i] == 7) ? 7 : m_hold[i] + 1;
            else
                m_hold[i] = 0;
            m_lvld[i] = req[i];
            m_ldir[i] = dr[i];
        end
        @(negedge board_clk);
        check("done_busy", 32'(busy), 0);
        check("done_grant", 32'(grant), 0);
        check_pos("after_b");
    endtask

    task automatic recenter_test();
        int seen;
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge board_clk);
            if (tick) begin seen = 1; break; end
        end
        if (seen == 0) begin
            check("rc_tick_timeout", 0, 1);
            return;
        end
        @(negedge board_clk);
        recenter = 1'b1;
        @(negedge board_clk);
        check("rc_grant", 32'(grant), 0);
        recenter = 1'b0;
        model_clear();
        last_tick = -1;
        check("rc_busy", 32'(busy), 0);
        check_pos("rc");
        for (int i = 0; i < 3; i++) begin
            @(negedge board_clk);
            check("rc_quiet_grant", 32'(grant), 0);
        end
        check_pos("rc_hold");
    endtask

    initial begin
        reset = 1'b1; recenter = 1'b0;
        p1_up = 1'b0; p1_dn = 1'b0; p2_up = 1'b0; p2_dn = 1'b0;
        m_rr = 0;
        model_clear();
        repeat (3) @(negedge board_clk);
        check("rst_grant", 32'(grant), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tick", 32'(tick), 0);
        check_pos("rst");
        reset = 1'b0;

        do_tick(4'b0001);
        do_tick(4'b0110);
        do_tick(4'b0110);
        for (int i = 0; i < 3; i++) do_tick(4'b1100);
        for (int i = 0; i < 44; i++) do_tick(4'b1001);
        for (int i = 0; i < 3; i++) do_tick(4'b0110);
        recenter_test();
`ifdef PADDLE_ACCEL_EN
        for (int i = 0; i < 12; i++) do_tick(4'b0010);
        do_tick(4'b0000);
        do_tick(4'b0010);
`endif
        for (int i = 0; i < 60; i++) do_tick(4'($urandom_range(0, 15)));
        recenter_test();
        for (int i = 0; i < 10; i++) do_tick(4'($urandom_range(0, 15)));

        // Asynchronous reset in the middle of service
        do_tick(4'b0101);
        do_tick(4'b0101);
        @(negedge board_clk);
        @(negedge board_clk);
        #1 reset = 1'b1;
        #1;
        check("arst_busy", 32'(busy), 0);
        check("arst_grant", 32'(grant), 0);
        check("arst_p1", 32'(p1_pos), 240);
        check("arst_p2", 32'(p2_pos), 240);
        @(negedge board_clk);
        reset = 1'b0;
        m_rr = 0;
        model_clear();
        last_tick = -1;
        for (int i = 0; i < 4; i++) do_tick(4'b0110);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
